// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode set, operand/result widths, staged request
// record and the combinational ALU function.
package alu_pkg;

   localparam int OPND_W = 4;
   localparam int RES_W  = 8;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5,
      OP_NOT = 3'd6,
      OP_SHL = 3'd7
   } opcode_e;

   typedef struct packed {
      opcode_e             op;
      logic [OPND_W-1:0]   a;
      logic [OPND_W-1:0]   b;
   } req_t;

   // Operands are zero-extended; every result is naturally modulo 256.
   function automatic logic [RES_W-1:0] alu_fn(input opcode_e op,
                                               input logic [OPND_W-1:0] a,
                                               input logic [OPND_W-1:0] b);
      logic [RES_W-1:0] ax;
      logic [RES_W-1:0] bx;
      logic [RES_W-1:0] r;
      ax = {4'h0, a};
      bx = {4'h0, b};
      case (op)
         OP_ADD:  r = ax + bx;
         OP_SUB:  r = ax - bx;
         OP_MUL:  r = ax * bx;
         OP_AND:  r = ax & bx;
         OP_OR:   r = ax | bx;
         OP_XOR:  r = ax ^ bx;
         OP_NOT:  r = {4'h0, ~a};
         OP_SHL:  r = ax << b[2:0];
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_fifo2.sv
// Two-entry, 8-bit synchronous FIFO with occupancy count. The caller never
// pushes into a full FIFO unless it pops on the same edge.
module alu_fifo2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] pop_data,
   output logic [1:0] count
);

   logic [7:0] mem [2];
   logic       wr_ptr;
   logic       rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/alu_resp.sv
// Request/response ALU: one-entry operand stage feeding a two-entry result
// FIFO, with a wrapping counter of consumed results.
module alu_resp
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       a,
   input  logic [3:0]       b,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       outdata,
   output logic [CNT_W-1:0] result_count
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1. out_valid/outdata hold steady until consumed; in_ready depends
   // only on registered occupancy (and rst), never on in_valid or out_ready.

   logic       s_valid;
   req_t       s_req;
   logic [1:0] fifo_count;
   logic [2:0] occupancy;
   logic       accept;
   logic       pop;
   logic       xfer;
   logic [7:0] s_result;

   assign occupancy = {2'b00, s_valid} + {1'b0, fifo_count};
   assign in_ready  = !rst && (occupancy < 3'd3);
   assign out_valid = (fifo_count != 2'd0);
   assign pop       = out_valid && out_ready;
   assign xfer      = s_valid && ((fifo_count < 2'd2) || pop);
   assign accept    = in_valid && in_ready;
   assign s_result  = alu_fn(s_req.op, s_req.a, s_req.b);

   // An accept always coincides with S being empty or moving out this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_valid <= 1'b0;
         s_req   <= '0;
      end else if (accept) begin
         s_valid <= 1'b1;
         s_req   <= '{op: opcode_e'(opcode), a: a, b: b};
      end else if (xfer) begin
         s_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         result_count <= '0;
      else if (pop)
         result_count <= result_count + 1'b1;
   end

   alu_fifo2 u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (xfer),
      .push_data (s_result),
      .pop       (pop),
      .pop_data  (outdata),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_alu_resp.sv
// Bench for alu_resp: directed scenarios plus randomized traffic checked
// against an arithmetic reference model and an in-order expected queue.
module tb_alu_resp;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic [2:0] opcode = '0;
   logic       out_ready = 1'b0;

   logic        in_ready, out_valid;
   logic [7:0]  outdata;
   logic [15:0] result_count;
   logic        in_ready4, out_valid4;
   logic [7:0]  outdata4;
   logic [3:0]  result_count4;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         pops     = 0;
   int         accepted = 0;
   logic [7:0] exp_q[$];
   logic       hold_prev = 1'b0;
   logic [7:0] hold_data = '0;

   alu_resp dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid),
      .out_ready(out_ready), .outdata(outdata), .result_count(result_count)
   );

   alu_resp #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid4),
      .out_ready(out_ready), .outdata(outdata4), .result_count(result_count4)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // reference model: plain integer arithmetic, reduced modulo 256
   function automatic logic [7:0] model(input logic [2:0] op,
                                        input logic [3:0] ma,
                                        input logic [3:0] mb);
      int x, y, r;
      x = ma;
      y = mb;
      case (op)
         3'd0:    r = x + y;
         3'd1:    r = x - y;
         3'd2:    r = x * y;
         3'd3:    r = x & y;
         3'd4:    r = x | y;
         3'd5:    r = x ^ y;
         3'd6:    r = 15 - x;
         default: r = x * (1 << (y % 8));
      endcase
      r = ((r % 256) + 256) % 256;
      return 8'(r);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver: one clock cycle; inputs set just after negedge, sampled #1 later
   task automatic cycle(input logic v, input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic [2:0] op, input logic ordy,
                        input logic [7:0] exp_val, output logic acc);
      in_valid  = v;
      a         = ta;
      b         = tb_v;
      opcode    = op;
      out_ready = ordy;
      #1;
      chk("result_count", {16'h0, result_count}, 32'(pops % 65536));
      chk("result_count_w4", {28'h0, result_count4}, 32'(pops % 16));
      if (hold_prev) begin
         chk("hold_valid", {31'h0, out_valid}, 32'd1);
         chk("hold_data", {24'h0, outdata}, {24'h0, hold_data});
      end
      if (exp_q.size() == 0)
         chk("valid_when_empty", {31'h0, out_valid}, 32'd0);
      if (out_valid && out_ready) begin
         if (exp_q.size() != 0)
            chk("outdata", {24'h0, outdata}, {24'h0, exp_q.pop_front()});
         pops++;
      end
      acc = v && in_ready;
      if (acc) begin
         exp_q.push_back(exp_val);
         accepted++;
      end
      hold_prev = out_valid && !ordy;
      hold_data = outdata;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
      chk("rst_outdata", {24'h0, outdata}, 32'h0);
      chk("rst_result_count", {16'h0, result_count}, 32'd0);
      chk("rst_result_count_w4", {28'h0, result_count4}, 32'd0);
      exp_q.delete();
      pops      = 0;
      hold_prev = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_held_in_ready", {31'h0, in_ready}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", {31'h0, in_ready}, 32'd1);
      @(negedge clk);
   endtask

   task automatic drain(input int max_cycles);
      logic acc;
      for (int i = 0; i < max_cycles; i++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         cycle(1'b0, 4'h0, 4'h0, 3'd0, 1'b1, 8'h00, acc);
      end
      chk("drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic       acc;
      logic [7:0] tbl[8];
      logic [7:0] ff_tbl[4];
      logic [2:0] ff_ops[4];
      int         base, n, j;
      logic [3:0] ra, rb;
      logic [2:0] rop;
      logic       rv, rr;

      tbl    = '{8'h0E, 8'hFC, 8'h2D, 8'h01, 8'h0D, 8'h0C, 8'h0A, 8'h0A};
      ff_tbl = '{8'h1E, 8'h00, 8'hE1, 8'h80};
      ff_ops = '{3'd0, 3'd1, 3'd2, 3'd7};

      @(negedge clk);
      do_reset();

      // a=5, b=9, all opcodes back to back, two-edge latency
      for (int k = 0; k < 11; k++) begin
         cycle(k < 8, 4'h5, 4'h9, 3'(k), 1'b1, (k < 8) ? tbl[k] : 8'h00, acc);
         chk("lat_out_valid", {31'h0, out_valid}, (k >= 1 && k <= 8) ? 32'd1 : 32'd0);
         if (k >= 1 && k <= 8)
            chk("lat_outdata", {24'h0, outdata}, {24'h0, tbl[k-1]});
         chk("throughput_in_ready", {31'h0, in_ready}, 32'd1);
      end

      // a=F, b=F corner results
      for (int k = 0; k < 4; k++)
         cycle(1'b1, 4'hF, 4'hF, ff_ops[k], 1'b1, ff_tbl[k], acc);
      drain(6);

      // back-pressure: three accepted, fourth held until a pop frees space
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 4'(i + 1), 4'h2, 3'd0, 1'b0, 8'(i + 3), acc);
         chk("fill_accept", {31'h0, acc}, (i < 3) ? 32'd1 : 32'd0);
      end
      chk("full_in_ready", {31'h0, in_ready}, 32'd0);
      j = 0;
      acc = 1'b0;
      while (!acc && j < 10) begin
         cycle(1'b1, 4'h4, 4'h2, 3'd0, 1'b1, 8'h06, acc);
         if (!acc) j++;
      end
      chk("accept_after_pop", 32'(j), 32'd1);
      drain(8);

      // randomized traffic, 1000 requests
      do_reset();
      base = accepted;
      n = 0;
      while ((accepted - base) < 1000 && n < 20000) begin
         rv  = 1'($urandom_range(0, 1));
         rr  = ($urandom_range(0, 3) != 0);
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         rop = 3'($urandom_range(0, 7));
         cycle(rv, ra, rb, rop, rr, model(rop, ra, rb), acc);
         n++;
      end
      chk("random_accepted", 32'(accepted - base), 32'd1000);
      drain(20);
      chk("random_result_count", {16'h0, result_count}, 32'd1000);

      // reset with three entries in flight; stale results must not reappear
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 4'(i + 7), 4'h1, 3'd5, 1'b0, model(3'd5, 4'(i + 7), 4'h1), acc);
      chk("occupied_out_valid", {31'h0, out_valid}, 32'd1);
      do_reset();
      cycle(1'b1, 4'h3, 4'h4, 3'd2, 1'b1, 8'h0C, acc);
      chk("post_rst_accept", {31'h0, acc}, 32'd1);
      drain(6);
      chk("post_rst_count", {16'h0, result_count}, 32'd1);

      // counter wrap on the 4-bit instance
      do_reset();
      for (int i = 0; i < 17; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         cycle(1'b1, ra, rb, 3'd4, 1'b1, model(3'd4, ra, rb), acc);
      end
      drain(6);
      chk("wrap_count_w4", {28'h0, result_count4}, 32'd1);
      chk("wrap_count_w16", {16'h0, result_count}, 32'd17);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
